rotary_accel_counter: RTL
=========================

Name: rotary_accel_counter

Overview:
- Downstream consumer of the rotary decoder's one-cycle rotary_event / rotary_left pulses.
- Keeps a bounded user value (volume, menu index, tempo) that increments on right turns and decrements on left turns.
- Applies velocity acceleration: fast, same-direction turning switches to a larger step.
- Feeds display and control logic with a registered value and a change strobe.

Parameters:
- WIDTH, 8, width of value
- MIN_VALUE, 0, lower bound, inclusive
- MAX_VALUE, 255, upper bound, inclusive; MIN_VALUE < MAX_VALUE <= 2^WIDTH-1
- RESET_VALUE, 0, value after reset or clear; must lie in [MIN_VALUE, MAX_VALUE]
- FAST_WINDOW, 2500000, max cycles between events for them to count as "fast"
- FAST_COUNT, 3, consecutive fast same-direction events required to enter FAST
- FAST_STEP, 4, step size while in FAST; normal step is 1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rotary_event  in  1  one-cycle pulse, one detent
- rotary_left  in  1  direction qualifier, 1 = left/decrement; ignored when rotary_event = 0
- clear  in  1  synchronous clear to RESET_VALUE
- value  out  WIDTH  current value, registered
- value_changed  out  1  one-cycle pulse, asserted in the first cycle a new value is visible
- fast  out  1  high while in FAST state

Behaviour:
- Reset (rst = 0, async): value = RESET_VALUE, value_changed = 0, fast = 0, state = IDLE, streak = 0, timer saturated at FAST_WINDOW, last_dir = 0.
- Interval timer:
  - Cleared to 0 on every accepted event.
  - Otherwise increments each cycle and saturates at FAST_WINDOW.
  - An event is "fast" iff timer < FAST_WINDOW and rotary_left == last_dir.
- States:
  - IDLE: no recent activity.
  - SLOW: activity, step 1.
  - FAST: step FAST_STEP.
- Transitions on an event:
  - From IDLE: go to SLOW, streak = 0.
  - From SLOW, fast event: streak++ (saturating). When streak reaches FAST_COUNT-1, go to FAST.
  - From SLOW, non-fast event: stay in SLOW, streak = 0.
  - From FAST, fast event: stay in FAST.
  - From FAST, non-fast event (direction change or late): go to SLOW, streak = 0.
- Timeout: timer reaching FAST_WINDOW while in SLOW or FAST goes to IDLE, streak = 0.
- Step selection uses the state before the event. The event that causes entry into FAST steps by 1; the following events step by FAST_STEP.
- Arithmetic:
  - Computed at WIDTH+1 bits.
  - Right turn: value + step, clamped to MAX_VALUE.
  - Left turn: value - step, clamped to MIN_VALUE. Underflow is detected via the extra bit.
  - Partial steps clamp to the bound, e.g. 253 + 4 gives 255.
- Latency: value and value_changed update in the cycle after the rotary_event pulse (1-cycle latency); fast updates in that same cycle.
- value_changed pulses only when the new value differs from the old. An event at a bound in the same direction produces no pulse, but still updates state, timer and last_dir.
- last_dir is updated on every accepted event.
- clear:
  - Priority over a simultaneous event; the event is dropped.
  - Sets value to RESET_VALUE, state to IDLE, streak to 0, timer to saturated.
  - value_changed pulses only if value differed from RESET_VALUE.
- Back-to-back events on consecutive cycles must each be applied; no event is lost.
- Reset asserted mid-operation returns to reset values immediately, with no pending update.

Optional Feature:
- Macro: ROTARY_WRAP_EN
- Defined: value wraps instead of saturating. With range = MAX_VALUE - MIN_VALUE + 1, new value = MIN_VALUE + ((value - MIN_VALUE ± step) mod range). value_changed pulses on every accepted event, since the range is > 1.
- Undefined: saturating behaviour as above.

Decomposition:
- Package rotary_pkg:
  - state enum (IDLE, SLOW, FAST)
  - direction constants (DIR_RIGHT = 0, DIR_LEFT = 1)
  - a width-helper function giving the timer width from FAST_WINDOW
- Sub-module rotary_interval_timer:
  - inputs: clk, rst, restart
  - output: expired
  - saturating counter to FAST_WINDOW
- Top block: FSM, streak counter and value arithmetic.

Test Plan:
- Bench parameters: FAST_WINDOW = 16, FAST_COUNT = 3, FAST_STEP = 4, range 0..255, RESET_VALUE = 0.
- Reset release, then one right event -> value 1 one cycle later, value_changed single pulse, fast = 0.
- 5 right events spaced 4 cycles -> values 1, 2, 3 (FAST entered on 3rd), then 7, 11; fast = 1 after 3rd event.
- While in FAST, a left event at 4-cycle spacing -> drops to SLOW, value decrements by 1; then 20 idle cycles -> state IDLE, fast = 0.
- value = 254, fast right event -> 255 with pulse; next right event -> 255, no pulse. Left from 0 -> stays 0, no pulse.
- clear asserted in the same cycle as an event at value 10 -> value 0, pulse, event ignored, fast = 0.
- ROTARY_WRAP_EN: value 255 + right event -> 0 with pulse; in FAST at 254 + right -> 2; value 0 + left in SLOW -> 255.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared types and helpers for the rotary accelerated counter.
// State encoding, turn direction codes and the interval timer width helper.
package rotary_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Bits needed to hold 0..window inclusive.
    function automatic int timer_width(input int window);
        int w;
        w = $clog2(window + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rotary_interval_timer.sv
// Measures cycles since the last accepted detent, saturating at FAST_WINDOW.
// expired is high once the saturation point has been reached.
module rotary_interval_timer
    import rotary_pkg::*;
#(
    parameter int FAST_WINDOW = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic saturate,
    output logic expired
);

    localparam int TW = timer_width(FAST_WINDOW);
    localparam logic [TW-1:0] WINDOW = TW'(FAST_WINDOW);

    logic [TW-1:0] count_p1;

    // Stage p1: interval count; saturate wins so a clear never looks like fresh activity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_p1 <= WINDOW;
        end else if (saturate) begin
            count_p1 <= WINDOW;
        end else if (restart) begin
            count_p1 <= '0;
        end else if (count_p1 != WINDOW) begin
            count_p1 <= count_p1 + TW'(1);
        end
    end

    assign expired = (count_p1 == WINDOW);

endmodule

// File: rtl/rotary_accel_counter.sv
// Bounded up/down value driven by rotary detent pulses, with velocity acceleration.
// Define ROTARY_WRAP_EN to wrap around the range instead of clamping at the bounds.
module rotary_accel_counter
    import rotary_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MIN_VALUE   = 0,
    parameter int MAX_VALUE   = 255,
    parameter int RESET_VALUE = 0,
    parameter int FAST_WINDOW = 2500000,
    parameter int FAST_COUNT  = 3,
    parameter int FAST_STEP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rotary_event,
    input  logic             rotary_left,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             value_changed,
    output logic             fast
);

    localparam int XW = WIDTH + 1;
    localparam int SW = (FAST_COUNT < 2) ? 1 : $clog2(FAST_COUNT);

    localparam logic [XW-1:0]    MIN_X     = XW'(MIN_VALUE);
    localparam logic [XW-1:0]    MAX_X     = XW'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RESET_V   = WIDTH'(RESET_VALUE);
    localparam logic [XW-1:0]    STEP_SLOW = XW'(1);
    localparam logic [XW-1:0]    STEP_FAST = XW'(FAST_STEP);
    localparam logic [SW-1:0]    STREAK_TARGET = SW'(FAST_COUNT - 1);
    localparam logic [SW-1:0]    STREAK_MAX    = {SW{1'b1}};
`ifdef ROTARY_WRAP_EN
    localparam logic [XW-1:0]    RANGE_X   = XW'(MAX_VALUE - MIN_VALUE + 1);
`endif

    // Increment by s; the extra bit keeps the intermediate sum from overflowing.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v,
                                                 input logic [XW-1:0] s);
        logic [XW-1:0] t;
`ifdef ROTARY_WRAP_EN
        t = {1'b0, v} - MIN_X + s;
        if (t >= RANGE_X) t = t - RANGE_X;
        t = t + MIN_X;
`else
        t = {1'b0, v} + s;
        if (t > MAX_X) t = MAX_X;
`endif
        return t[WIDTH-1:0];
    endfunction

    // Decrement by s; a set top bit after subtraction means the value went below zero.
    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v,
                                                   input logic [XW-1:0] s);
        logic [XW-1:0] t;
`ifdef ROTARY_WRAP_EN
        t = {1'b0, v} - MIN_X;
        if (t >= s) t = t - s;
        else        t = t + RANGE_X - s;
        t = t + MIN_X;
`else
        t = {1'b0, v} - s;
        if (t[WIDTH] || (t < MIN_X)) t = MIN_X;
`endif
        return t[WIDTH-1:0];
    endfunction

    state_t           state_p1, state_nxt;
    logic [SW-1:0]    streak_p1, streak_nxt, streak_inc;
    logic             last_dir_p1, last_dir_nxt;
    logic [WIDTH-1:0] value_p1, value_nxt, stepped;
    logic             changed_p1, changed_nxt;
    logic [XW-1:0]    step;
    logic             expired;
    logic             fast_evt;

    rotary_interval_timer #(
        .FAST_WINDOW(FAST_WINDOW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (rotary_event & ~clear),
        .saturate(clear),
        .expired (expired)
    );

    assign fast_evt = ~expired & (rotary_left == last_dir_p1);

    // Stage p0: next state, streak and value from the current detent
    always_comb begin
        state_nxt    = state_p1;
        streak_nxt   = streak_p1;
        last_dir_nxt = last_dir_p1;
        value_nxt    = value_p1;
        changed_nxt  = 1'b0;
        // Large step only while already accelerating and the turn keeps its pace and direction
        step         = ((state_p1 == FAST) && fast_evt) ? STEP_FAST : STEP_SLOW;
        stepped      = (rotary_left == DIR_LEFT) ? step_down(value_p1, step)
                                                 : step_up(value_p1, step);
        streak_inc   = (streak_p1 == STREAK_MAX) ? streak_p1 : streak_p1 + SW'(1);

        if (clear) begin
            value_nxt   = RESET_V;
            changed_nxt = (value_p1 != RESET_V);
            state_nxt   = IDLE;
            streak_nxt  = '0;
        end else if (rotary_event) begin
            value_nxt    = stepped;
            changed_nxt  = (stepped != value_p1);
            last_dir_nxt = rotary_left;
            case (state_p1)
                IDLE: begin
                    state_nxt  = SLOW;
                    streak_nxt = '0;
                end
                SLOW: begin
                    if (fast_evt) begin
                        streak_nxt = streak_inc;
                        if (streak_inc >= STREAK_TARGET) state_nxt = FAST;
                    end else begin
                        streak_nxt = '0;
                    end
                end
                FAST: begin
                    if (!fast_evt) begin
                        state_nxt  = SLOW;
                        streak_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    streak_nxt = '0;
                end
            endcase
        end else if (expired && (state_p1 != IDLE)) begin
            state_nxt  = IDLE;
            streak_nxt = '0;
        end
    end

    // Stage p1: registered value, change strobe and acceleration state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1    <= IDLE;
            streak_p1   <= '0;
            last_dir_p1 <= DIR_RIGHT;
            value_p1    <= RESET_V;
            changed_p1  <= 1'b0;
        end else begin
            state_p1    <= state_nxt;
            streak_p1   <= streak_nxt;
            last_dir_p1 <= last_dir_nxt;
            value_p1    <= value_nxt;
            changed_p1  <= changed_nxt;
        end
    end

    assign value         = value_p1;
    assign value_changed = changed_p1;
    assign fast          = (state_p1 == FAST);

endmodule
